// File: rtl/axi4l_arb2.sv
// axi4l_arb2 -- two-requester AXI4-Lite arbiter in front of one shared slave.
//
// Purpose: lets requesters s0 and s1 share a single AXI4-Lite register-bank
// slave. One transaction is outstanding at a time. Requesters are served
// round-robin, and a requester's write wins over its own read. Address, data,
// strobe, prot and resp paths are pure muxes with no added latency. Only the
// FSM state, the grant, the last grant and the AW/W done flags are registered.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   s0_axi_* / s1_axi_* AXI4-Lite slave-side ports of requesters 0 and 1
//   m_axi_*             AXI4-Lite master-side port to the shared slave
//   busy                a transaction is currently granted (state not IDLE)
//   gnt                 index of the current or most recently granted requester
module axi4l_arb2 #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // requester 0
  input  logic [AW-1:0] s0_axi_awaddr,
  input  logic [2:0]    s0_axi_awprot,
  input  logic          s0_axi_awvalid,
  output logic          s0_axi_awready,
  input  logic [31:0]   s0_axi_wdata,
  input  logic [3:0]    s0_axi_wstrb,
  input  logic          s0_axi_wvalid,
  output logic          s0_axi_wready,
  output logic [1:0]    s0_axi_bresp,
  output logic          s0_axi_bvalid,
  input  logic          s0_axi_bready,
  input  logic [AW-1:0] s0_axi_araddr,
  input  logic [2:0]    s0_axi_arprot,
  input  logic          s0_axi_arvalid,
  output logic          s0_axi_arready,
  output logic [31:0]   s0_axi_rdata,
  output logic [1:0]    s0_axi_rresp,
  output logic          s0_axi_rvalid,
  input  logic          s0_axi_rready,
  // requester 1
  input  logic [AW-1:0] s1_axi_awaddr,
  input  logic [2:0]    s1_axi_awprot,
  input  logic          s1_axi_awvalid,
  output logic          s1_axi_awready,
  input  logic [31:0]   s1_axi_wdata,
  input  logic [3:0]    s1_axi_wstrb,
  input  logic          s1_axi_wvalid,
  output logic          s1_axi_wready,
  output logic [1:0]    s1_axi_bresp,
  output logic          s1_axi_bvalid,
  input  logic          s1_axi_bready,
  input  logic [AW-1:0] s1_axi_araddr,
  input  logic [2:0]    s1_axi_arprot,
  input  logic          s1_axi_arvalid,
  output logic          s1_axi_arready,
  output logic [31:0]   s1_axi_rdata,
  output logic [1:0]    s1_axi_rresp,
  output logic          s1_axi_rvalid,
  input  logic          s1_axi_rready,
  // shared slave
  output logic [AW-1:0] m_axi_awaddr,
  output logic [2:0]    m_axi_awprot,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [31:0]   m_axi_wdata,
  output logic [3:0]    m_axi_wstrb,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  input  logic [1:0]    m_axi_bresp,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready,
  output logic [AW-1:0] m_axi_araddr,
  output logic [2:0]    m_axi_arprot,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  input  logic [31:0]   m_axi_rdata,
  input  logic [1:0]    m_axi_rresp,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready,
  // status
  output logic          busy,
  output logic          gnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WB   = 3'd2,
    RD   = 3'd3,
    RR   = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_gnt_q, last_gnt_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic   req0_s, req1_s, win_s, win_wr_s;
  logic   sel_awvalid_s, sel_wvalid_s, sel_bready_s, sel_arvalid_s, sel_rready_s;
  logic   aw_hs_s, w_hs_s;
  // Handshake-side signals of the granted requester, demuxed onto s0/s1 below.
  logic   g_awready_s, g_wready_s, g_bvalid_s, g_arready_s, g_rvalid_s;

  assign req0_s   = s0_axi_awvalid | s0_axi_arvalid;
  assign req1_s   = s1_axi_awvalid | s1_axi_arvalid;
  // On contention the requester that was not served last wins.
  // A sole requester always wins.
  assign win_s    = (req0_s && req1_s) ? ~last_gnt_q : req1_s;
  assign win_wr_s = win_s ? s1_axi_awvalid : s0_axi_awvalid;

  // Request-side muxes: these follow the registered grant.
  assign sel_awvalid_s = gnt_q ? s1_axi_awvalid : s0_axi_awvalid;
  assign sel_wvalid_s  = gnt_q ? s1_axi_wvalid  : s0_axi_wvalid;
  assign sel_bready_s  = gnt_q ? s1_axi_bready  : s0_axi_bready;
  assign sel_arvalid_s = gnt_q ? s1_axi_arvalid : s0_axi_arvalid;
  assign sel_rready_s  = gnt_q ? s1_axi_rready  : s0_axi_rready;

  assign m_axi_awaddr = gnt_q ? s1_axi_awaddr : s0_axi_awaddr;
  assign m_axi_awprot = gnt_q ? s1_axi_awprot : s0_axi_awprot;
  assign m_axi_wdata  = gnt_q ? s1_axi_wdata  : s0_axi_wdata;
  assign m_axi_wstrb  = gnt_q ? s1_axi_wstrb  : s0_axi_wstrb;
  assign m_axi_araddr = gnt_q ? s1_axi_araddr : s0_axi_araddr;
  assign m_axi_arprot = gnt_q ? s1_axi_arprot : s0_axi_arprot;

  // Response payloads go to both requesters. Only the granted requester ever
  // sees a valid.
  assign s0_axi_bresp = m_axi_bresp;
  assign s1_axi_bresp = m_axi_bresp;
  assign s0_axi_rdata = m_axi_rdata;
  assign s1_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s1_axi_rresp = m_axi_rresp;

  assign s0_axi_awready = g_awready_s & ~gnt_q;
  assign s1_axi_awready = g_awready_s &  gnt_q;
  assign s0_axi_wready  = g_wready_s  & ~gnt_q;
  assign s1_axi_wready  = g_wready_s  &  gnt_q;
  assign s0_axi_bvalid  = g_bvalid_s  & ~gnt_q;
  assign s1_axi_bvalid  = g_bvalid_s  &  gnt_q;
  assign s0_axi_arready = g_arready_s & ~gnt_q;
  assign s1_axi_arready = g_arready_s &  gnt_q;
  assign s0_axi_rvalid  = g_rvalid_s  & ~gnt_q;
  assign s1_axi_rvalid  = g_rvalid_s  &  gnt_q;

  // A channel that has already completed its handshake must not handshake again.
  assign aw_hs_s = sel_awvalid_s & ~aw_done_q & m_axi_awready;
  assign w_hs_s  = sel_wvalid_s  & ~w_done_q  & m_axi_wready;

  assign busy = (state_q != IDLE);
  assign gnt  = gnt_q;

  // Next-state, grant and done-flag logic, plus all valid/ready handshake outputs.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    g_awready_s   = 1'b0;
    g_wready_s    = 1'b0;
    g_bvalid_s    = 1'b0;
    g_arready_s   = 1'b0;
    g_rvalid_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_s || req1_s) begin
          gnt_d   = win_s;
          state_d = win_wr_s ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        m_axi_awvalid = sel_awvalid_s & ~aw_done_q;
        m_axi_wvalid  = sel_wvalid_s  & ~w_done_q;
        g_awready_s   = m_axi_awready & ~aw_done_q;
        g_wready_s    = m_axi_wready  & ~w_done_q;
        aw_done_d     = aw_done_q | aw_hs_s;
        w_done_d      = w_done_q  | w_hs_s;
        if (aw_done_d && w_done_d) begin
          state_d = WB;
        end else begin
          state_d = WR;
        end
      end
      WB: begin
        m_axi_bready = sel_bready_s;
        g_bvalid_s   = m_axi_bvalid;
        if (m_axi_bvalid && sel_bready_s) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          last_gnt_d = gnt_q;
          state_d    = IDLE;
        end else begin
          state_d = WB;
        end
      end
      RD: begin
        m_axi_arvalid = sel_arvalid_s;
        g_arready_s   = m_axi_arready;
        if (sel_arvalid_s && m_axi_arready) begin
          state_d = RR;
        end else begin
          state_d = RD;
        end
      end
      RR: begin
        m_axi_rready = sel_rready_s;
        g_rvalid_s   = m_axi_rvalid;
        if (m_axi_rvalid && sel_rready_s) begin
          last_gnt_d = gnt_q;
          state_d    = IDLE;
        end else begin
          state_d = RR;
        end
      end
      default: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and grant registers. last_gnt resets to 1 so requester 0 wins the
  // first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi4l_arb2.sv
// tb_axi4l_arb2 -- directed self-checking bench for axi4l_arb2.
// The bench plays both requesters and the shared slave. Inputs change
// 1 time unit after the rising edge. Outputs are sampled shortly after that,
// well before the next edge.
module tb_axi4l_arb2;

  logic        clk, rst;
  logic [31:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic [2:0]  s0_axi_awprot, s1_axi_awprot, s0_axi_arprot, s1_axi_arprot;
  logic        s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
  logic [31:0] s0_axi_wdata, s1_axi_wdata;
  logic [3:0]  s0_axi_wstrb, s1_axi_wstrb;
  logic        s0_axi_wvalid, s1_axi_wvalid, s0_axi_wready, s1_axi_wready;
  logic [1:0]  s0_axi_bresp, s1_axi_bresp;
  logic        s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
  logic        s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic [31:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp;
  logic        s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;
  logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic        busy, gnt;

  int checks = 0;
  int errors = 0;

  axi4l_arb2 #(.AW(32)) dut (
    .clk(clk), .rst(rst),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awprot(s0_axi_awprot),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arprot(s0_axi_arprot),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awprot(s1_axi_awprot),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arprot(s1_axi_arprot),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Entry: IDLE with requester 'who' already presenting AW+W.
  // The slave accepts AW and W in the same cycle.
  task automatic wr_txn(input int who, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp);
    tick();
    check("wr_gnt", gnt, who);
    check("wr_busy", busy, 1'b1);
    check("wr_awvalid", m_axi_awvalid, 1'b1);
    check("wr_awaddr", m_axi_awaddr, addr);
    check("wr_wdata", m_axi_wdata, data);
    check("wr_wstrb", m_axi_wstrb, strb);
    check("wr_no_ar", m_axi_arvalid, 1'b0);
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    #1;
    check("wr_awready_g", (who == 1) ? s1_axi_awready : s0_axi_awready, 1'b1);
    check("wr_wready_g", (who == 1) ? s1_axi_wready : s0_axi_wready, 1'b1);
    check("wr_awready_o", (who == 1) ? s0_axi_awready : s1_axi_awready, 1'b0);
    check("wr_arready_o", (who == 1) ? s0_axi_arready : s1_axi_arready, 1'b0);
    tick();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    if (who == 1) begin s1_axi_awvalid = 1'b0; s1_axi_wvalid = 1'b0; end
    else begin s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; end
    #1;
    check("wb_awvalid", m_axi_awvalid, 1'b0);
    check("wb_bready", m_axi_bready, 1'b1);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    #1;
    check("wb_bvalid_g", (who == 1) ? s1_axi_bvalid : s0_axi_bvalid, 1'b1);
    check("wb_bresp_g", (who == 1) ? s1_axi_bresp : s0_axi_bresp, resp);
    check("wb_bvalid_o", (who == 1) ? s0_axi_bvalid : s1_axi_bvalid, 1'b0);
    tick();
    m_axi_bvalid = 1'b0;
    #1;
    check("wr_end_busy", busy, 1'b0);
    check("wr_end_bready", m_axi_bready, 1'b0);
  endtask

  // Entry: IDLE with requester 'who' presenting AR
  // (and no write of higher priority pending).
  task automatic rd_txn(input int who, input logic [31:0] addr, input logic [31:0] data);
    tick();
    check("rd_gnt", gnt, who);
    check("rd_arvalid", m_axi_arvalid, 1'b1);
    check("rd_araddr", m_axi_araddr, addr);
    check("rd_no_aw", m_axi_awvalid, 1'b0);
    m_axi_arready = 1'b1;
    #1;
    check("rd_arready_g", (who == 1) ? s1_axi_arready : s0_axi_arready, 1'b1);
    check("rd_arready_o", (who == 1) ? s0_axi_arready : s1_axi_arready, 1'b0);
    tick();
    m_axi_arready = 1'b0;
    if (who == 1) s1_axi_arvalid = 1'b0;
    else s0_axi_arvalid = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = data;
    #1;
    check("rr_arvalid", m_axi_arvalid, 1'b0);
    check("rr_rready", m_axi_rready, 1'b1);
    check("rr_rvalid_g", (who == 1) ? s1_axi_rvalid : s0_axi_rvalid, 1'b1);
    check("rr_rdata_g", (who == 1) ? s1_axi_rdata : s0_axi_rdata, data);
    check("rr_rvalid_o", (who == 1) ? s0_axi_rvalid : s1_axi_rvalid, 1'b0);
    tick();
    m_axi_rvalid = 1'b0;
    #1;
    check("rd_end_busy", busy, 1'b0);
    check("rd_end_rready", m_axi_rready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    s0_axi_awaddr = 32'h0; s1_axi_awaddr = 32'h0; s0_axi_araddr = 32'h0; s1_axi_araddr = 32'h0;
    s0_axi_awprot = 3'd0; s1_axi_awprot = 3'd0; s0_axi_arprot = 3'd0; s1_axi_arprot = 3'd0;
    s0_axi_awvalid = 1'b0; s1_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; s1_axi_wvalid = 1'b0;
    s0_axi_wdata = 32'h0; s1_axi_wdata = 32'h0; s0_axi_wstrb = 4'h0; s1_axi_wstrb = 4'h0;
    s0_axi_bready = 1'b1; s1_axi_bready = 1'b1; s0_axi_rready = 1'b1; s1_axi_rready = 1'b1;
    s0_axi_arvalid = 1'b0; s1_axi_arvalid = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;

    // Reset state
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt, 1'b0);
    check("rst_awvalid", m_axi_awvalid, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_bready", m_axi_bready, 1'b0);
    check("rst_rready", m_axi_rready, 1'b0);

    // Single write from s0
    s0_axi_awaddr = 32'h4; s0_axi_wdata = 32'hDEADBEEF; s0_axi_wstrb = 4'hF;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1;
    m_axi_awready = 1'b1;
    #1;
    check("idle_awvalid", m_axi_awvalid, 1'b0);
    check("idle_awready", s0_axi_awready, 1'b0);
    m_axi_awready = 1'b0;
    wr_txn(0, 32'h4, 32'hDEADBEEF, 4'hF, 2'b00);

    // Simultaneous reads after reset: s0 first, then s1
    do_reset();
    s0_axi_araddr = 32'h0; s1_axi_araddr = 32'h4;
    s0_axi_arvalid = 1'b1; s1_axi_arvalid = 1'b1;
    rd_txn(0, 32'h0, 32'h11111111);
    rd_txn(1, 32'h4, 32'h22222222);

    // s0 write+read vs s1 read: s0 write, s1 read, s0 read
    do_reset();
    s0_axi_awaddr = 32'h10; s0_axi_wdata = 32'hCAFEF00D; s0_axi_wstrb = 4'h3;
    s0_axi_awvalid = 1'b1; s0_axi_wvalid = 1'b1;
    s0_axi_araddr = 32'h14; s0_axi_arvalid = 1'b1;
    s1_axi_araddr = 32'h18; s1_axi_arvalid = 1'b1;
    wr_txn(0, 32'h10, 32'hCAFEF00D, 4'h3, 2'b00);
    rd_txn(1, 32'h18, 32'h33333333);
    rd_txn(0, 32'h14, 32'h44444444);

    // s1 write, AW and W accepted in different cycles, then B stalled
    s1_axi_awaddr = 32'h8; s1_axi_wdata = 32'h12345678; s1_axi_wstrb = 4'hC;
    s1_axi_awvalid = 1'b1; s1_axi_wvalid = 1'b1;
    tick();
    check("sep_gnt", gnt, 1'b1);
    m_axi_awready = 1'b1;
    #1;
    check("sep_awready", s1_axi_awready, 1'b1);
    check("sep_wready0", s1_axi_wready, 1'b0);
    check("sep_s0_awready", s0_axi_awready, 1'b0);
    tick();
    s1_axi_awvalid = 1'b0;
    #1;
    check("sep_aw_once", m_axi_awvalid, 1'b0);
    check("sep_wvalid", m_axi_wvalid, 1'b1);
    check("sep_no_wb", m_axi_bready, 1'b0);
    m_axi_wready = 1'b1;
    #1;
    check("sep_wready", s1_axi_wready, 1'b1);
    check("sep_aw_ready_gated", s1_axi_awready, 1'b0);
    tick();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; s1_axi_wvalid = 1'b0;
    s1_axi_bready = 1'b0; m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    s0_axi_araddr = 32'hC; s0_axi_arvalid = 1'b1;
    #1;
    check("stall_wvalid", m_axi_wvalid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_busy", busy, 1'b1);
      check("stall_gnt", gnt, 1'b1);
      check("stall_bready", m_axi_bready, 1'b0);
      check("stall_bvalid", s1_axi_bvalid, 1'b1);
      check("stall_no_ar", m_axi_arvalid, 1'b0);
      check("stall_s0_arready", s0_axi_arready, 1'b0);
    end
    s1_axi_bready = 1'b1;
    #1;
    check("stall_bready_go", m_axi_bready, 1'b1);
    check("stall_bresp", s1_axi_bresp, 2'b10);
    tick();
    m_axi_bvalid = 1'b0;
    #1;
    check("stall_end_busy", busy, 1'b0);
    rd_txn(0, 32'hC, 32'h55555555);

    // Reset pulsed mid-transaction in RR
    s0_axi_araddr = 32'h20; s0_axi_arvalid = 1'b1;
    tick();
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0; s0_axi_arvalid = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h66666666;
    #1;
    check("rr_pre_rst_rvalid", s0_axi_rvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_gnt", gnt, 1'b0);
    check("arst_rvalid", s0_axi_rvalid, 1'b0);
    check("arst_rready", m_axi_rready, 1'b0);
    check("arst_arvalid", m_axi_arvalid, 1'b0);
    m_axi_rvalid = 1'b0;
    #1;
    rst = 1'b0;
    s1_axi_araddr = 32'h24; s1_axi_arvalid = 1'b1;
    rd_txn(1, 32'h24, 32'h77777777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4l_arb2.md
AXI4L_ARB2 -- requirements
Module: axi4l_arb2

Interface
REQ-001: Parameter AW, default 32, byte-address width on all ports.
REQ-002: Port clk in 1: the single clock; all logic on rising edge.
REQ-003: Port rst in 1: reset, asynchronous and active-high.
REQ-004: Ports s0_axi_awaddr in AW, s0_axi_awprot in 3, s0_axi_awvalid in 1, s0_axi_awready out 1: requester 0 write-address channel.
REQ-005: Ports s0_axi_wdata in 32, s0_axi_wstrb in 4, s0_axi_wvalid in 1, s0_axi_wready out 1: requester 0 write-data channel.
REQ-006: Ports s0_axi_bresp out 2, s0_axi_bvalid out 1, s0_axi_bready in 1: requester 0 write-response channel.
REQ-007: Ports s0_axi_araddr in AW, s0_axi_arprot in 3, s0_axi_arvalid in 1, s0_axi_arready out 1: requester 0 read-address channel.
REQ-008: Ports s0_axi_rdata out 32, s0_axi_rresp out 2, s0_axi_rvalid out 1, s0_axi_rready in 1: requester 0 read-data channel.
REQ-009: Ports s1_axi_* are identical to REQ-004..008 and form requester 1.
REQ-010: Ports m_axi_* mirror REQ-004..008 with directions reversed and connect to the single shared AXI4-Lite register-bank slave.
REQ-011: Port busy out 1: a transaction is granted (state not IDLE).
REQ-012: Port gnt out 1: index of the current or most recent granted requester.

Function
REQ-013: FSM states are IDLE, WR (AW/W forward), WB (B wait), RD (AR forward), RR (R wait); only one transaction is outstanding at the slave at a time.
REQ-014: Write request of requester i = si_axi_awvalid; read request = si_axi_arvalid.
REQ-015: In IDLE with any request, the arbiter registers the grant and moves to WR or RD on the next edge; IDLE drives no valid/ready outputs.
REQ-016: Requesters are arbitrated round-robin: the requester not equal to last_gnt wins when both request; a sole requester always wins.
REQ-017: Within the winning requester, write has priority over read.
REQ-018: In WR, m_axi_aw* and m_axi_w* carry the granted requester's signals; the granted awready/wready equal m_axi_awready/wready.
REQ-019: In WR, aw_done and w_done flags set on their respective handshakes; m_axi_awvalid/wvalid are forced 0 once their flag is set; WR goes to WB when both are done (including the same cycle).
REQ-020: In WB, m_axi_bready = granted bready, granted bvalid/bresp = m_axi_bvalid/bresp; the B handshake clears the flags, sets last_gnt = gnt, and returns to IDLE.
REQ-021: In RD, m_axi_ar* carry the granted requester's signals; the AR handshake moves to RR.
REQ-022: In RR, rdata/rresp/rvalid pass to the granted requester and rready passes back; the R handshake sets last_gnt and returns to IDLE.
REQ-023: The non-granted requester sees all readys and valids at 0 in every state; its pending valids are held and served later.
REQ-024: Data, address, strobe, prot and resp paths are combinational muxes with zero added latency; only the state, gnt, last_gnt and done flags are registered.
REQ-025: m_axi valids are 0 outside the matching state; m_axi_bready is 0 outside WB; m_axi_rready is 0 outside RR.
REQ-026: Minimum transaction spacing is 1 IDLE cycle between successive grants.

Reset
REQ-027: Asserting rst at any time, including mid-transaction, forces state IDLE, gnt 0, last_gnt 1, done flags 0, busy 0, and all valid/ready outputs 0 asynchronously.
REQ-028: After rst deasserts, the first simultaneous contention is won by requester 0.

Verification
REQ-029: Single write: s0 writes 0xDEADBEEF to 0x4, strb 0xF -> slave sees awaddr 0x4 and wdata 0xDEADBEEF; s0 gets bresp 00; s1 readys stay 0.
REQ-030: Simultaneous s0 and s1 reads of 0x0 and 0x4 -> s0 is served first, then s1 after one IDLE cycle; each gets its own rdata.
REQ-031: s0 asserts both awvalid and arvalid while s1 asserts arvalid -> order is s0 write, s1 read, then s0 read.
REQ-032: Slave takes awready and wready in different cycles, and separately in the same cycle -> exactly one AW and one W handshake reach the slave, then WB.
REQ-033: Slave holds bvalid and requester holds bready low for 5 cycles -> state stays WB, and no new grant is made until the handshake.
REQ-034: rst pulsed while in RR -> all outputs reach their REQ-027 values without a clock edge; a request after release is granted normally.
